// File: rtl/phase_sequencer.sv
// Machine-cycle timing generator: one-hot beats T0..T(N-1) with free-run,
// single-step and boundary-aligned stop, plus a wrapping completed-cycle counter.
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step,
    input  logic                  stop,
    input  logic                  halt,
    output logic [NUM_PHASES-1:0] phase,
    output logic [IDX_W-1:0]      phase_idx,
    output logic                  cycle_end,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [NUM_PHASES-1:0] PHASE_T0   = {{(NUM_PHASES-1){1'b0}}, 1'b1};
    localparam logic [NUM_PHASES-1:0] PHASE_NONE = {NUM_PHASES{1'b0}};

    state_t                  state_r,     state_s;
    logic [NUM_PHASES-1:0]   phase_r,     phase_s;
    logic [IDX_W-1:0]        idx_r,       idx_s;
    logic [CNT_W-1:0]        count_r,     count_s;
    logic                    stop_pend_r, stop_pend_s;
    logic                    last_beat_s;

    assign last_beat_s = phase_r[NUM_PHASES-1];

    // State register: all sequencing state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            phase_r     <= PHASE_NONE;
            idx_r       <= {IDX_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            stop_pend_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            idx_r       <= idx_s;
            count_r     <= count_s;
            stop_pend_r <= stop_pend_s;
        end
    end

    // Next-state logic: a started machine cycle always runs to its last beat.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        idx_s       = idx_r;
        count_s     = count_r;
        stop_pend_s = stop_pend_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    phase_s = PHASE_T0;
                    idx_s   = {IDX_W{1'b0}};
                end else if (step) begin
                    state_s = STEP;
                    phase_s = PHASE_T0;
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            RUN, STEP: begin
                if (last_beat_s) begin
                    count_s = count_r + CNT_W'(1);
                    idx_s   = {IDX_W{1'b0}};
                    if (halt) begin
                        state_s = HALTED;
                        phase_s = PHASE_NONE;
                    end else if ((state_r == STEP) || stop_pend_r || stop) begin
                        state_s     = IDLE;
                        phase_s     = PHASE_NONE;
                        stop_pend_s = 1'b0;
                    end else begin
                        state_s = RUN;
                        phase_s = PHASE_T0;
                    end
                end else begin
                    phase_s = phase_r << 1;
                    idx_s   = idx_r + IDX_W'(1);
                    if ((state_r == RUN) && stop) begin
                        stop_pend_s = 1'b1;
                    end else begin
                        stop_pend_s = stop_pend_r;
                    end
                end
            end
            HALTED: begin
                state_s = HALTED;
            end
            default: begin
                state_s     = IDLE;
                phase_s     = PHASE_NONE;
                idx_s       = {IDX_W{1'b0}};
                stop_pend_s = 1'b0;
            end
        endcase
    end

    // Output decode: status flags derived purely from registered state.
    always_comb begin
        running   = 1'b0;
        halted    = 1'b0;
        cycle_end = last_beat_s;
        case (state_r)
            RUN, STEP: running = 1'b1;
            HALTED:    halted  = 1'b1;
            IDLE:      running = 1'b0;
            default:   running = 1'b0;
        endcase
    end

    assign phase       = phase_r;
    assign phase_idx   = idx_r;
    assign cycle_count = count_r;

endmodule
